inv_cipher: RTL and testbench

// - AES inverse cipher (FIPS-197 InvCipher): decrypts one 128-bit block, one round per clock.
// - Decrypt-side counterpart of the encryption cipher; consumes the same 1920-bit expanded key from key expansion.
// - Supports AES-128/192/256 via NR = 10/12/14; start/valid handshake, one block in flight.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/inv_round.sv | 61 ++++++
 rtl/inv_cipher.sv | 106 ++++++++++
 tb/tb_inv_cipher.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the inverse cipher.
package aes_pkg;

    localparam int NB        = 4;
    localparam int BLOCK_W   = 128;
    localparam int MAX_NR    = 14;
    localparam int KEY_BUS_W = BLOCK_W * (MAX_NR + 1);

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } state_e;

    // Round key r lives at [KEY_BUS_W-1-128*r -: 128]; constant-index mux keeps every select in range.
    function automatic logic [BLOCK_W-1:0] rk_sel(input logic [KEY_BUS_W-1:0] key_bus,
                                                  input logic [3:0]           r);
        logic [BLOCK_W-1:0] k;
        k = '0;
        for (int i = 0; i <= MAX_NR; i++) begin
            if (r == 4'(i)) k = key_bus[KEY_BUS_W-1-BLOCK_W*i -: BLOCK_W];
        end
        return k;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] acc;
        logic [7:0] sq;
        acc = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational AES decryption round; InvMixColumns is skipped on the final round.
module inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_state,
    input  logic [BLOCK_W-1:0] i_key,
    input  logic               i_last,
    output logic [BLOCK_W-1:0] o_state
);

    // Byte b of a block sits at [127-8*b -: 8], with b = row + 4*column.
    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int c = 0; c < NB; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[BLOCK_W-1-8*(row+4*c) -: 8] = s[BLOCK_W-1-8*(row+4*((c-row+NB)%NB)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_sub_bytes(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int b = 0; b < 4*NB; b++) begin
            r[BLOCK_W-1-8*b -: 8] = inv_sbox(s[BLOCK_W-1-8*b -: 8]);
        end
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] add_round_key(input logic [BLOCK_W-1:0] s,
                                                         input logic [BLOCK_W-1:0] k);
        return s ^ k;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        logic [7:0]         a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < NB; c++) begin
            a0 = s[BLOCK_W-1-8*(4*c)   -: 8];
            a1 = s[BLOCK_W-1-8*(4*c+1) -: 8];
            a2 = s[BLOCK_W-1-8*(4*c+2) -: 8];
            a3 = s[BLOCK_W-1-8*(4*c+3) -: 8];
            r[BLOCK_W-1-8*(4*c)   -: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
            r[BLOCK_W-1-8*(4*c+1) -: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
            r[BLOCK_W-1-8*(4*c+2) -: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
            r[BLOCK_W-1-8*(4*c+3) -: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
        end
        return r;
    endfunction

    logic [BLOCK_W-1:0] keyed;

    always_comb begin
        keyed   = add_round_key(inv_sub_bytes(inv_shift_rows(i_state)), i_key);
        o_state = i_last ? keyed : inv_mix_columns(keyed);
    end

endmodule

// File: rtl/inv_cipher.sv
// AES inverse cipher, one round per clock, for AES-128/192/256 selected by NR at start.
//   state | meaning
//   IDLE  | waiting for start; NR checked, initial AddRoundKey(key[NR]) applied on accept
//   ROUND | one inverse round per cycle, key[cnt]; cnt==0 is the final round
module inv_cipher
    import aes_pkg::BLOCK_W, aes_pkg::NR_128, aes_pkg::NR_192, aes_pkg::NR_256,
           aes_pkg::state_e, aes_pkg::IDLE, aes_pkg::ROUND, aes_pkg::rk_sel;
#(
    parameter int MAX_NR    = 14,
    parameter int KEY_BUS_W = 1920
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BLOCK_W-1:0]   i_data,
    input  logic [3:0]           NR,
    input  logic [KEY_BUS_W-1:0] expanded_key,
    output logic                 busy,
    output logic                 o_valid,
    output logic                 o_err,
    output logic [BLOCK_W-1:0]   o_data
);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic [BLOCK_W-1:0] rk_init;
    logic [BLOCK_W-1:0] rk_round;
    logic [BLOCK_W-1:0] round_out;
    logic               last_round;
    logic               nr_legal;

    assign nr_legal   = (NR == NR_128 || NR == NR_192 || NR == NR_256) && (NR <= 4'(MAX_NR));
    assign last_round = (cnt_q == 4'd0);
    assign rk_init    = rk_sel(expanded_key, NR);
    assign rk_round   = rk_sel(expanded_key, cnt_q);

    inv_round u_inv_round (
        .i_state (blk_q),
        .i_key   (rk_round),
        .i_last  (last_round),
        .o_state (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (nr_legal) begin
                        blk_d   = i_data ^ rk_init;
                        cnt_d   = NR - 4'd1;
                        state_d = ROUND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ROUND: begin
                // start is deliberately not looked at here; a block in flight cannot be disturbed.
                blk_d = round_out;
                if (!last_round) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d  = round_out;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == ROUND);
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_data  = data_q;

endmodule

// File: tb/tb_inv_cipher.sv
// Self-checking bench for inv_cipher: FIPS-197 vectors, handshake corner cases, random blocks vs a table-based model.
module tb_inv_cipher;

    typedef struct {
        logic [3:0]   nr;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [127:0]    i_data = '0;
    logic [3:0]      nr = '0;
    logic [1919:0]   expanded_key = '0;
    logic            busy, o_valid, o_err;
    logic [127:0]    o_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_t [256];
    logic [7:0] log_t [256];
    logic [7:0] sb    [256];
    logic [7:0] isb   [256];

    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    inv_cipher dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .i_data       (i_data),
        .NR           (nr),
        .expanded_key (expanded_key),
        .busy         (busy),
        .o_valid      (o_valid),
        .o_err        (o_err),
        .o_data       (o_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] v);
        return v[7] ? 8'((v << 1) ^ 8'h1b) : 8'(v << 1);
    endfunction

    // Exp/log tables over generator 3; S-box from inverse + affine map, inverse S-box by table inversion.
    task automatic build_tables();
        logic [7:0] x, b, s;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = 8'(i);
            x = x ^ xt(x);
        end
        for (int a = 0; a < 256; a++) begin
            b = (a == 0) ? 8'h00 : exp_t[(255 - int'(log_t[a])) % 255];
            s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            sb[a]  = s;
            isb[s] = 8'(a);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 0 || b == 0) return 8'h00;
        return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
    endfunction

    function automatic logic [1919:0] expand_key(input logic [255:0] key, input int n);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] kb;
        int            nk;
        nk   = n - 6;
        rcon = 8'h01;
        kb   = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(n+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 4*(n+1); i++) kb[1919-32*i -: 32] = w[i];
        return kb;
    endfunction

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [1919:0] kb, input int n);
        logic [7:0]   st [4][4];
        logic [7:0]   t  [4][4];
        logic [127:0] out;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                st[r][c] = ct[127-8*(r+4*c) -: 8] ^ kb[1919-128*n-8*(r+4*c) -: 8];
        for (int rd = n - 1; rd >= 0; rd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = isb[st[r][(c-r+4)%4]] ^ kb[1919-128*rd-8*(r+4*c) -: 8];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    st[r][c] = (rd == 0) ? t[r][c] :
                               gmul(8'h0e, t[r][c])       ^ gmul(8'h0b, t[(r+1)%4][c]) ^
                               gmul(8'h0d, t[(r+2)%4][c]) ^ gmul(8'h09, t[(r+3)%4][c]);
        end
        out = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                out[127-8*(r+4*c) -: 8] = st[r][c];
        return out;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called on the negedge after the start edge; lat counts further edges until o_valid.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_block(input string tag, input logic [127:0] ct, input logic [3:0] n,
                             input logic [127:0] want);
        int lat;
        @(negedge clk);
        start  = 1'b1;
        i_data = ct;
        nr     = n;
        @(negedge clk);
        start  = 1'b0;
        i_data = rnd128();
        nr     = 4'($urandom_range(0, 15));
        chk({tag, " busy_after_start"}, 128'(busy), 128'd1);
        wait_valid(lat);
        chk({tag, " latency"}, 128'(lat), 128'(n));
        chk({tag, " data"}, o_data, want);
        chk({tag, " busy_in_valid_cycle"}, 128'(busy), 128'd0);
        @(negedge clk);
        chk({tag, " valid_one_cycle"}, 128'(o_valid), 128'd0);
    endtask

    initial begin
        vec_t       vecs [3];
        int         lat;
        logic [3:0] n;
        logic [127:0] ct2, want2, ct;
        logic [255:0] key;
        bit         seen;

        build_tables();

        vecs[0].nr = 4'd10; vecs[0].key = K128;                                       vecs[0].ct = C1_CT;                                  vecs[0].pt = PT;
        vecs[1].nr = 4'd12; vecs[1].key = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
                                                                                      vecs[1].ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191; vecs[1].pt = PT;
        vecs[2].nr = 4'd14; vecs[2].key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
                                                                                      vecs[2].ct = 128'h8ea2b7ca516745bfeafc49904b496089; vecs[2].pt = PT;

        // Reset values, with inputs toggling under reset.
        rst_n  = 1'b0;
        start  = 1'b1;
        nr     = 4'd10;
        i_data = rnd128();
        repeat (3) @(negedge clk);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset o_valid", 128'(o_valid), 128'd0);
        chk("reset o_err", 128'(o_err), 128'd0);
        chk("reset o_data", o_data, 128'd0);
        start = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            expanded_key = expand_key(vecs[i].key, int'(vecs[i].nr));
            run_block($sformatf("fips%0d", i), vecs[i].ct, vecs[i].nr, vecs[i].pt);
        end

        // Back-to-back with an ignored start mid-block.
        expanded_key = expand_key(K128, 10);
        ct2   = rnd128();
        want2 = ref_decrypt(ct2, expanded_key, 10);
        @(negedge clk);
        start = 1'b1; i_data = C1_CT; nr = 4'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; i_data = rnd128(); nr = 4'd14;
        @(negedge clk);
        start = 1'b0;
        chk("b2b midstart no_err", 128'(o_err), 128'd0);
        chk("b2b midstart busy", 128'(busy), 128'd1);
        wait_valid(lat);
        chk("b2b first latency", 128'(lat + 4), 128'd10);
        chk("b2b first data", o_data, PT);
        start = 1'b1; i_data = ct2; nr = 4'd10;
        @(negedge clk);
        start = 1'b0;
        chk("b2b second busy", 128'(busy), 128'd1);
        wait_valid(lat);
        chk("b2b second latency", 128'(lat), 128'd10);
        chk("b2b second data", o_data, want2);

        // Illegal NR is rejected without touching o_data.
        @(negedge clk);
        start = 1'b1; nr = 4'd11; i_data = rnd128();
        @(negedge clk);
        start = 1'b0;
        chk("nr11 o_err", 128'(o_err), 128'd1);
        chk("nr11 busy", 128'(busy), 128'd0);
        chk("nr11 o_valid", 128'(o_valid), 128'd0);
        chk("nr11 o_data held", o_data, want2);
        @(negedge clk);
        chk("nr11 err one_cycle", 128'(o_err), 128'd0);
        chk("nr11 still idle", 128'(busy), 128'd0);
        run_block("after_nr11", C1_CT, 4'd10, PT);

        // Reset during round 5 of an AES-128 block.
        @(negedge clk);
        start = 1'b1; i_data = C1_CT; nr = 4'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", 128'(busy), 128'd0);
        chk("midreset o_valid", 128'(o_valid), 128'd0);
        chk("midreset o_err", 128'(o_err), 128'd0);
        chk("midreset o_data", o_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        chk("midreset no_valid", 128'(seen), 128'd0);
        run_block("after_reset", C1_CT, 4'd10, PT);

        // Random keys, key sizes and ciphertexts against the reference model.
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0:       n = 4'd10;
                1:       n = 4'd12;
                default: n = 4'd14;
            endcase
            key = {rnd128(), rnd128()};
            ct  = rnd128();
            expanded_key = expand_key(key, int'(n));
            run_block($sformatf("rand%0d_nr%0d", i, n), ct, n, ref_decrypt(ct, expanded_key, int'(n)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
